// File: rtl/freq_meas_pkg.sv
//==============================================================================
// freq_meas_pkg: shared widths, state codes and quotient saturation helper.
// Revision: 1.0
//==============================================================================
`default_nettype none

package freq_meas_pkg;

  localparam int CNT_W = 32;
  localparam int DIV_W = 64;
  localparam int ST_W  = 4;

  localparam logic [ST_W-1:0] ST_IDLE    = 4'd0;
  localparam logic [ST_W-1:0] ST_ARM     = 4'd1;
  localparam logic [ST_W-1:0] ST_GATE    = 4'd2;
  localparam logic [ST_W-1:0] ST_CLOSE   = 4'd3;
  localparam logic [ST_W-1:0] ST_MUL     = 4'd4;
  localparam logic [ST_W-1:0] ST_START   = 4'd5;
  localparam logic [ST_W-1:0] ST_WAIT_LO = 4'd6;
  localparam logic [ST_W-1:0] ST_WAIT_HI = 4'd7;
  localparam logic [ST_W-1:0] ST_CAPTURE = 4'd8;
  localparam logic [ST_W-1:0] ST_TOUT    = 4'd9;

  function automatic logic [CNT_W-1:0] sat_quotient(input logic [DIV_W-1:0] q);
    return (|q[DIV_W-1:CNT_W]) ? {CNT_W{1'b1}} : q[CNT_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/freq_meas_ctrl_sig_sync_edge.sv
//==============================================================================
// sig_sync_edge: 2-FF synchronizer with a registered rising-edge pulse.
// Revision: 1.0
//==============================================================================
`default_nettype none

module sig_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      meta <= async_in;
      sync <= meta;
      prev <= sync;
      rise <= sync & ~prev;
    end
  end

  assign level = sync;

endmodule

`default_nettype wire

// File: rtl/freq_meas_ctrl.sv
//==============================================================================
// freq_meas_ctrl: reciprocal frequency counter feeding an external 64/32 divider.
// Optional FREQ_ROUND_EN: round-to-nearest dividend, one extra MUL cycle.
// Revision: 1.0
//==============================================================================
`default_nettype none

module freq_meas_ctrl
  import freq_meas_pkg::*;
#(
  parameter int unsigned REF_HZ         = 64000000,
  parameter int unsigned GATE_CYCLES    = 64000000,
  parameter int unsigned TIMEOUT_CYCLES = 128000000
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             Meas_En,
  input  logic             Sig_In,
  output logic [DIV_W-1:0] Div_Dividend,
  output logic [CNT_W-1:0] Div_Divisor,
  output logic             Div_Start,
  input  logic             Div_Done,
  input  logic [DIV_W-1:0] Div_Quotient,
  output logic [CNT_W-1:0] Freq_Hz,
  output logic             Freq_Valid,
  output logic             Timeout
);

  localparam logic [CNT_W-1:0] GATE_LAST   = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLOSE_LIMIT = CNT_W'(GATE_CYCLES + TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] ARM_LIMIT   = CNT_W'(TIMEOUT_CYCLES);

  logic [ST_W-1:0]  state;
  logic [CNT_W-1:0] nx;
  logic [CNT_W-1:0] nb;
  logic [CNT_W-1:0] tmr;
  logic [DIV_W-1:0] dividend;
  logic [CNT_W-1:0] divisor;
  logic             div_start;
  logic [CNT_W-1:0] freq_hz;
  logic             freq_valid;
  logic             timeout;

  logic sig_level;
  logic sig_rise;
  logic done_s;
  logic done_rise;
  logic unused_sync;

  logic [DIV_W-1:0] product;
  logic [CNT_W-1:0] nb_inc;
  logic [CNT_W-1:0] tmr_inc;

`ifdef FREQ_ROUND_EN
  logic mul_phase;
`endif

  sig_sync_edge u_sig_sync (
    .clk      (CLK),
    .rst_n    (RST_N),
    .async_in (Sig_In),
    .level    (sig_level),
    .rise     (sig_rise)
  );

  sig_sync_edge u_done_sync (
    .clk      (CLK),
    .rst_n    (RST_N),
    .async_in (Div_Done),
    .level    (done_s),
    .rise     (done_rise)
  );

  assign unused_sync = sig_level ^ done_rise;

  // REF_HZ < 2^31 keeps the product below 2^63
  assign product = DIV_W'(nx) * DIV_W'(REF_HZ);
  assign nb_inc  = nb + 1'b1;
  assign tmr_inc = tmr + 1'b1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= ST_IDLE;
      nx         <= '0;
      nb         <= '0;
      tmr        <= '0;
      dividend   <= '0;
      divisor    <= '0;
      div_start  <= 1'b0;
      freq_hz    <= '0;
      freq_valid <= 1'b0;
      timeout    <= 1'b0;
`ifdef FREQ_ROUND_EN
      mul_phase  <= 1'b0;
`endif
    end else begin
      div_start  <= 1'b0;
      freq_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          tmr <= '0;
          if (Meas_En) state <= ST_ARM;
        end
        ST_ARM: begin
          if (!Meas_En) begin
            state <= ST_IDLE;
          end else if (sig_rise) begin
            state <= ST_GATE;
            nx    <= '0;
            nb    <= '0;
            tmr   <= '0;
          end else if (tmr_inc == ARM_LIMIT) begin
            state      <= ST_TOUT;
            freq_hz    <= '0;
            freq_valid <= 1'b1;
            timeout    <= 1'b1;
          end else begin
            tmr <= tmr_inc;
          end
        end
        ST_GATE: begin
          if (!Meas_En) begin
            state <= ST_IDLE;
          end else begin
            nb <= nb_inc;
            if (sig_rise) nx <= nx + 1'b1;
            if (nb_inc == GATE_LAST) state <= ST_CLOSE;
          end
        end
        ST_CLOSE: begin
          if (!Meas_En) begin
            state <= ST_IDLE;
          end else begin
            nb <= nb_inc;
            if (sig_rise) begin
              nx    <= nx + 1'b1;
              state <= ST_MUL;
`ifdef FREQ_ROUND_EN
              mul_phase <= 1'b0;
`endif
            end else if (nb_inc == CLOSE_LIMIT) begin
              state      <= ST_TOUT;
              freq_hz    <= '0;
              freq_valid <= 1'b1;
              timeout    <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          divisor <= nb;
`ifdef FREQ_ROUND_EN
          if (!mul_phase) begin
            dividend  <= product;
            mul_phase <= 1'b1;
          end else begin
            dividend  <= dividend + DIV_W'(nb >> 1);
            div_start <= 1'b1;
            state     <= ST_START;
          end
`else
          dividend  <= product;
          div_start <= 1'b1;
          state     <= ST_START;
`endif
        end
        ST_START: state <= ST_WAIT_LO;
        // a stale done level from the previous operation must drop first
        ST_WAIT_LO: if (!done_s) state <= ST_WAIT_HI;
        ST_WAIT_HI: begin
          if (done_s) begin
            freq_hz    <= sat_quotient(Div_Quotient);
            freq_valid <= 1'b1;
            timeout    <= 1'b0;
            state      <= ST_CAPTURE;
          end
        end
        ST_CAPTURE, ST_TOUT: begin
          tmr   <= '0;
          state <= Meas_En ? ST_ARM : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign Div_Dividend = dividend;
  assign Div_Divisor  = divisor;
  assign Div_Start    = div_start;
  assign Freq_Hz      = freq_hz;
  assign Freq_Valid   = freq_valid;
  assign Timeout      = timeout;

endmodule

`default_nettype wire

// File: tb/tb_freq_meas_ctrl.sv
//==============================================================================
// tb_freq_meas_ctrl: directed bench with a gate-arithmetic reference model.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_freq_meas_ctrl;

  localparam int unsigned REF   = 1000;
  localparam int unsigned GATE  = 100;
  localparam int unsigned TOUTC = 400;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        Meas_En;
  logic        Sig_In;
  logic [63:0] Div_Dividend;
  logic [31:0] Div_Divisor;
  logic        Div_Start;
  logic        Div_Done;
  logic [63:0] Div_Quotient;
  logic [31:0] Freq_Hz;
  logic        Freq_Valid;
  logic        Timeout;

  freq_meas_ctrl #(.REF_HZ(REF), .GATE_CYCLES(GATE), .TIMEOUT_CYCLES(TOUTC)) dut (
    .CLK(CLK), .RST_N(RST_N), .Meas_En(Meas_En), .Sig_In(Sig_In),
    .Div_Dividend(Div_Dividend), .Div_Divisor(Div_Divisor), .Div_Start(Div_Start),
    .Div_Done(Div_Done), .Div_Quotient(Div_Quotient), .Freq_Hz(Freq_Hz),
    .Freq_Valid(Freq_Valid), .Timeout(Timeout)
  );

  always #5 CLK = ~CLK;

  typedef struct { longint unsigned dd; int unsigned dv; } start_t;
  typedef struct { int unsigned hz; bit tout; } res_t;

  start_t start_q[$];
  res_t   res_q[$];

  int vectors = 0;
  int errors  = 0;
  int valid_cnt = 0;
  int start_cnt = 0;
  int sig_period = 0;
  int lo_delay = 2;
  bit sat_force = 1'b0;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Gate opens on one signal rise and closes on the first rise at or beyond GATE cycles
  task automatic push_meas(input int p);
    int unsigned nx;
    int unsigned nb;
    longint unsigned dd;
    nx = (GATE + p - 1) / p;
    nb = nx * p;
    dd = longint'(nx) * REF;
`ifdef FREQ_ROUND_EN
    dd = dd + nb / 2;
`endif
    start_q.push_back('{dd, nb});
    res_q.push_back('{int'(dd / nb), 1'b0});
  endtask

  // Signal generator
  initial begin
    Sig_In = 1'b0;
    forever begin
      if (sig_period == 0) begin
        Sig_In = 1'b0;
        @(negedge CLK);
      end else begin
        int p;
        p = sig_period;
        Sig_In = 1'b1;
        repeat (p / 2) @(negedge CLK);
        Sig_In = 1'b0;
        repeat (p - p / 2) @(negedge CLK);
      end
    end
  end

  // Behavioural divider, done latency 40 cycles
  initial begin
    longint unsigned dd;
    longint unsigned dv;
    Div_Done = 1'b0;
    Div_Quotient = '0;
    forever begin
      @(negedge CLK);
      if (Div_Start && RST_N) begin
        dd = Div_Dividend;
        dv = Div_Divisor;
        repeat (lo_delay) @(negedge CLK);
        Div_Done = 1'b0;
        repeat (40 - lo_delay) @(negedge CLK);
        Div_Quotient = sat_force ? 64'h1_0000_0005 : ((dv == 0) ? 64'd0 : dd / dv);
        Div_Done = 1'b1;
      end
    end
  end

  // Compare process
  bit busy = 1'b0;
  start_t hold;
  always @(negedge CLK) begin
    if (!RST_N) begin
      busy = 1'b0;
    end else begin
      if (Div_Start) begin
        start_cnt++;
        if (start_q.size() == 0) begin
          chk("unexpected_start", 1, 0);
        end else begin
          hold = start_q.pop_front();
          chk("dividend", Div_Dividend, hold.dd);
          chk("divisor", Div_Divisor, hold.dv);
          busy = 1'b1;
        end
      end else if (busy) begin
        chk("dividend_hold", Div_Dividend, hold.dd);
        chk("divisor_hold", Div_Divisor, hold.dv);
      end
      if (Freq_Valid) begin
        valid_cnt++;
        busy = 1'b0;
        if (res_q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          res_t r;
          r = res_q.pop_front();
          chk("freq_hz", Freq_Hz, r.hz);
          chk("timeout_flag", Timeout, r.tout);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
    #1;
  endtask

  task automatic wait_valids(input int target, input int budget, input string nm, output int n);
    n = 0;
    while (valid_cnt < target && n < budget) begin
      @(negedge CLK);
      #1;
      n++;
    end
    chk(nm, valid_cnt >= target, 1);
  endtask

  task automatic wait_start(input int target, input int budget, input string nm);
    int n;
    n = 0;
    while (start_cnt < target && n < budget) begin
      @(negedge CLK);
      #1;
      n++;
    end
    chk(nm, start_cnt >= target, 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_freq"}, Freq_Hz, 0);
    chk({tag, "_valid"}, Freq_Valid, 0);
    chk({tag, "_tout"}, Timeout, 0);
    chk({tag, "_start"}, Div_Start, 0);
    chk({tag, "_dd"}, Div_Dividend, 0);
    chk({tag, "_dv"}, Div_Divisor, 0);
  endtask

  initial begin
    #(400000 * 10);
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int sc;
    RST_N = 1'b0;
    Meas_En = 1'b0;
    tick(3);
    check_zero("reset");
    RST_N = 1'b1;

    // Period 10, two back-to-back measurements
    sig_period = 10;
    tick(30);
    push_meas(10);
    push_meas(10);
    Meas_En = 1'b1;
    wait_valids(2, 1000, "p10_wait", n);
    Meas_En = 1'b0;
    chk("p10_freq_lit", Freq_Hz, 100);
    chk("p10_dd_lit", Div_Dividend, 10000);
    chk("p10_dv_lit", Div_Divisor, 100);
    chk("p10_tout_lit", Timeout, 0);
    tick(20);

    // Period 7, stale done level dropping late
    sig_period = 7;
    lo_delay = 20;
    tick(30);
    push_meas(7);
    Meas_En = 1'b1;
    wait_valids(3, 1000, "p7_wait", n);
    Meas_En = 1'b0;
    lo_delay = 2;
`ifdef FREQ_ROUND_EN
    chk("p7_freq_lit", Freq_Hz, 143);
    chk("p7_dd_lit", Div_Dividend, 15052);
`else
    chk("p7_freq_lit", Freq_Hz, 142);
    chk("p7_dd_lit", Div_Dividend, 15000);
`endif
    chk("p7_dv_lit", Div_Divisor, 105);
    tick(20);

    // Quotient overflow saturates
    sig_period = 10;
    sat_force = 1'b1;
    tick(30);
    push_meas(10);
    void'(res_q.pop_back());
    res_q.push_back('{32'hFFFF_FFFF, 1'b0});
    Meas_En = 1'b1;
    wait_valids(4, 1000, "sat_wait", n);
    Meas_En = 1'b0;
    sat_force = 1'b0;
    chk("sat_freq_lit", Freq_Hz, 32'hFFFF_FFFF);
    tick(50);

    // Stuck-low signal times out, next good result clears the flag
    sig_period = 0;
    tick(10);
    res_q.push_back('{0, 1'b1});
    Meas_En = 1'b1;
    wait_valids(5, 1000, "tout_wait", n);
    Meas_En = 1'b0;
    chk("tout_latency", (n >= 398 && n <= 404), 1);
    chk("tout_freq_lit", Freq_Hz, 0);
    chk("tout_flag_lit", Timeout, 1);
    sig_period = 10;
    tick(30);
    push_meas(10);
    Meas_En = 1'b1;
    wait_valids(6, 1000, "recover_wait", n);
    Meas_En = 1'b0;
    chk("recover_tout_lit", Timeout, 0);
    tick(20);

    // Enable dropped mid-gate: nothing issued, result unchanged
    sc = start_cnt;
    Meas_En = 1'b1;
    tick(60);
    Meas_En = 1'b0;
    tick(300);
    chk("abort_starts", start_cnt, sc);
    chk("abort_valids", valid_cnt, 6);
    chk("abort_freq_lit", Freq_Hz, 100);

    // Enable dropped while waiting on the divider: result still reported
    sig_period = 7;
    tick(30);
    push_meas(7);
    sc = start_cnt;
    Meas_En = 1'b1;
    wait_start(sc + 1, 1000, "late_drop_start");
    tick(10);
    Meas_En = 1'b0;
    wait_valids(7, 200, "late_drop_wait", n);
    tick(300);
    chk("late_drop_starts", start_cnt, sc + 1);
    chk("late_drop_valids", valid_cnt, 7);

    // Reset while waiting for done: outputs clear, late done ignored
    sig_period = 10;
    tick(30);
    push_meas(10);
    void'(res_q.pop_back());
    sc = start_cnt;
    Meas_En = 1'b1;
    wait_start(sc + 1, 1000, "rst_start");
    tick(10);
    Meas_En = 1'b0;
    RST_N = 1'b0;
    #1;
    check_zero("midrst");
    tick(2);
    RST_N = 1'b1;
    tick(100);
    chk("rst_no_valid", valid_cnt, 7);
    chk("rst_freq", Freq_Hz, 0);
    chk("start_q_empty", start_q.size(), 0);
    chk("res_q_empty", res_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
